// File: rtl/dot_pkg.sv
// -----------------------------------------------------------------------------
// dot_pkg
// Shared definitions for the digit-serial dot-product accumulator:
//   - dot_state_e : FSM state encoding (IDLE / COMPUTE / HOLD)
//   - SIGNED_EN   : 1 when the build treats a/b as two's complement
//   - calc_d      : number of digits per element (ELEM_W / DIGIT_W)
//   - calc_part_w : width of one digit-pass partial sum
//   - cfg_ok      : parameter sanity check used at elaboration
// Configuration macro: DOT_SIGNED_EN (undefined -> unsigned arithmetic).
// -----------------------------------------------------------------------------
package dot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_HOLD    = 2'd2
    } dot_state_e;

`ifdef DOT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    function automatic int calc_d(input int elem_w, input int digit_w);
        return elem_w / digit_w;
    endfunction

    // One extra bit in signed mode keeps the most negative product sum exact.
    function automatic int calc_part_w(input int digit_w, input int elem_w,
                                       input int lanes, input bit signed_en);
        return digit_w + elem_w + $clog2(lanes) + (signed_en ? 1 : 0);
    endfunction

    // The accumulator must at least hold one full digit-by-element product.
    function automatic bit cfg_ok(input int acc_w, input int elem_w, input int digit_w);
        return (acc_w >= elem_w + digit_w) && ((elem_w % digit_w) == 0);
    endfunction

endpackage

// File: rtl/dot_digit_tree.sv
// -----------------------------------------------------------------------------
// dot_digit_tree
// Combinational block: LANES digit-by-element multipliers followed by an adder
// tree. Produces partial = sum_i digit_i * b_i in PART_W bits.
// In signed builds (DOT_SIGNED_EN) the digit is sign-extended only when it is
// the top digit of its element; b is always sign-extended.
// Ports:
//   i_digits  [LANES*DIGIT_W] current digit of every a element
//   i_top     1               current digit is the most significant one
//   i_b       [LANES*ELEM_W]  full b elements
//   o_partial [PART_W]        sum of the LANES products (two's complement
//                             when signed)
// -----------------------------------------------------------------------------
module dot_digit_tree
    import dot_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int ELEM_W  = 16,
    parameter int DIGIT_W = 4,
    parameter int PART_W  = 23
) (
    input  logic [LANES*DIGIT_W-1:0] i_digits,
    input  logic                     i_top,
    input  logic [LANES*ELEM_W-1:0]  i_b,
    output logic [PART_W-1:0]        o_partial
);

    logic [PART_W-1:0] w_prod [LANES];
    logic [PART_W-1:0] w_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic              w_dig_sgn;
        logic              w_b_sgn;
        logic [PART_W-1:0] w_dig_x;
        logic [PART_W-1:0] w_b_x;

        assign w_dig_sgn = SIGNED_EN & i_top & i_digits[g*DIGIT_W + DIGIT_W - 1];
        assign w_b_sgn   = SIGNED_EN & i_b[g*ELEM_W + ELEM_W - 1];
        assign w_dig_x   = {{(PART_W-DIGIT_W){w_dig_sgn}}, i_digits[g*DIGIT_W +: DIGIT_W]};
        assign w_b_x     = {{(PART_W-ELEM_W){w_b_sgn}}, i_b[g*ELEM_W +: ELEM_W]};
        // Modular PART_W product is exact because the true value fits PART_W.
        assign w_prod[g] = w_dig_x * w_b_x;
    end

    // Sum all lane products.
    always_comb begin
        w_sum = {PART_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + w_prod[i];
        end
    end

    assign o_partial = w_sum;

endmodule

// File: rtl/dot_digit_accum.sv
// -----------------------------------------------------------------------------
// dot_digit_accum
// Digit-serial dot-product accumulator. Accepts a beat of LANES (a,b) pairs,
// walks the DIGIT_W-bit digits of a over D = ELEM_W/DIGIT_W cycles, and adds
// each shifted partial into an ACC_W accumulator. A beat flagged last parks
// the result in HOLD until the consumer takes it.
// Configuration macro: DOT_SIGNED_EN (two's complement a/b and signed ovf).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   clear          synchronous abort back to IDLE (drops accumulation)
//   in_valid/in_ready/in_last, a, b : input beat handshake and data
//   out_valid/out_ready, out_data, out_ovf : result handshake, value, sticky
//                                            overflow of this accumulation
// -----------------------------------------------------------------------------
module dot_digit_accum
    import dot_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int ELEM_W  = 16,
    parameter int DIGIT_W = 4,
    parameter int ACC_W   = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*ELEM_W-1:0] a,
    input  logic [LANES*ELEM_W-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf
);

    localparam int D      = calc_d(ELEM_W, DIGIT_W);
    localparam int PART_W = calc_part_w(DIGIT_W, ELEM_W, LANES, SIGNED_EN);
    localparam int CNT_W  = (D > 1) ? $clog2(D) : 1;
    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] ONE_D  = CNT_W'(1);

    if (!cfg_ok(ACC_W, ELEM_W, DIGIT_W)) begin : g_cfg_error
        $error("dot_digit_accum: ACC_W too small or ELEM_W not a multiple of DIGIT_W");
    end

    dot_state_e               r_state;
    dot_state_e               w_next;
    logic [LANES*ELEM_W-1:0]  r_a;
    logic [LANES*ELEM_W-1:0]  r_b;
    logic                     r_last;
    logic [CNT_W-1:0]         r_d;
    logic [ACC_W-1:0]         r_acc;
    logic                     r_ovf;
    logic                     r_in_ready;
    logic                     r_out_valid;

    logic [LANES*DIGIT_W-1:0] w_digits;
    logic                     w_digit_done;
    logic [PART_W-1:0]        w_partial;
    logic [ACC_W+PART_W-1:0]  w_part_wide;
    logic [ACC_W-1:0]         w_addend;
    logic [ACC_W:0]           w_sum_c;
    logic                     w_add_ovf;

    assign w_digit_done = (r_d == LAST_D);

    // Next-state logic; clear overrides every state.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) w_next = ST_COMPUTE;
                    else          w_next = ST_IDLE;
                end
                ST_COMPUTE: begin
                    if (w_digit_done) w_next = r_last ? ST_HOLD : ST_IDLE;
                    else              w_next = ST_COMPUTE;
                end
                ST_HOLD: begin
                    if (out_ready) w_next = ST_IDLE;
                    else           w_next = ST_HOLD;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ST_IDLE);
            r_out_valid <= (w_next == ST_HOLD);
        end
    end

    // Select digit r_d of every registered a element.
    always_comb begin
        w_digits = {(LANES*DIGIT_W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_digits[i*DIGIT_W +: DIGIT_W] = r_a[i*ELEM_W + int'(r_d)*DIGIT_W +: DIGIT_W];
        end
    end

    dot_digit_tree #(
        .LANES   (LANES),
        .ELEM_W  (ELEM_W),
        .DIGIT_W (DIGIT_W),
        .PART_W  (PART_W)
    ) u_tree (
        .i_digits  (w_digits),
        .i_top     (w_digit_done),
        .i_b       (r_b),
        .o_partial (w_partial)
    );

    // Extend (or truncate when PART_W > ACC_W) the partial, then align it.
    assign w_part_wide = {{ACC_W{SIGNED_EN & w_partial[PART_W-1]}}, w_partial};
    assign w_addend    = w_part_wide[ACC_W-1:0] << (int'(r_d) * DIGIT_W);
    assign w_sum_c     = {1'b0, r_acc} + {1'b0, w_addend};
    // Signed: same-sign operands yielding a different-sign result.
    assign w_add_ovf   = SIGNED_EN
                       ? ((r_acc[ACC_W-1] == w_addend[ACC_W-1]) &&
                          (w_sum_c[ACC_W-1] != r_acc[ACC_W-1]))
                       : w_sum_c[ACC_W];

    // Operand capture, digit counter, accumulator and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= {(LANES*ELEM_W){1'b0}};
            r_b    <= {(LANES*ELEM_W){1'b0}};
            r_last <= 1'b0;
            r_d    <= {CNT_W{1'b0}};
            r_acc  <= {ACC_W{1'b0}};
            r_ovf  <= 1'b0;
        end else if (clear) begin
            r_d    <= {CNT_W{1'b0}};
            r_acc  <= {ACC_W{1'b0}};
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_last <= in_last;
                        r_d    <= {CNT_W{1'b0}};
                    end
                end
                ST_COMPUTE: begin
                    r_acc <= w_sum_c[ACC_W-1:0];
                    r_ovf <= r_ovf | w_add_ovf;
                    r_d   <= w_digit_done ? {CNT_W{1'b0}} : (r_d + ONE_D);
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_acc <= {ACC_W{1'b0}};
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_d <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_dot_digit_accum.sv
// -----------------------------------------------------------------------------
// tb_dot_digit_accum
// Directed bench for dot_digit_accum: a default instance (ACC_W=48) and an
// ACC_W=20 instance share all inputs; the second one covers wrap/overflow.
// -----------------------------------------------------------------------------
module tb_dot_digit_accum;

    logic         clk = 1'b0;
    logic         rst, clear, in_valid, in_last, out_ready;
    logic [127:0] a, b;
    logic         in_ready, out_valid, out_ovf;
    logic [47:0]  out_data;
    logic         in_ready20, out_valid20, out_ovf20;
    logic [19:0]  out_data20;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dot_digit_accum u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    dot_digit_accum #(.ACC_W(20)) u_dut20 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready20),
        .in_last(in_last), .a(a), .b(b), .out_valid(out_valid20), .out_ready(out_ready),
        .out_data(out_data20), .out_ovf(out_ovf20)
    );

    function automatic logic [127:0] rep(input logic [15:0] v);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [127:0] ramp();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(i + 2);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a beat and return after its accepting edge.
    task automatic send_beat(input logic [127:0] va, input logic [127:0] vb, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        a = 128'd0; b = 128'd0;
        tick(); tick();
        rst = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if (in_ready20 !== 1'b1) begin bad++; $display("FAIL reset_in_ready20 got=%0b want=1", in_ready20); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_data !== 48'd0) begin bad++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%0b want=0", out_ovf); end
    endtask

    task automatic test_single();
        int cyc;
        send_beat(rep(16'h0001), ramp(), 1'b1);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_busy in_ready got=%0b want=0", in_ready); end
        wait_valid(cyc);
        total++; if (cyc != 4) begin bad++; $display("FAIL single_latency got=%0d want=4", cyc); end
        total++; if (out_data !== 48'd44) begin bad++; $display("FAIL single_data got=%0h want=2c", out_data); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%0b want=0", out_ovf); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_hold_ready got=%0b want=0", in_ready); end
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_drain_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_two_beats();
        int cyc;
        logic [47:0] exp;
`ifdef DOT_SIGNED_EN
        exp = 48'h0;
`else
        exp = 48'h80000;
`endif
        send_beat(rep(16'hFFFF), rep(16'h0001), 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL two_no_valid k=%0d got=%0b want=0", k, out_valid); end
            total++; if (in_ready !== (k == 4)) begin bad++; $display("FAIL two_ready k=%0d got=%0b want=%0b", k, in_ready, (k == 4)); end
        end
        send_beat(rep(16'h0001), rep(16'h0001), 1'b1);
        wait_valid(cyc);
        total++; if (cyc != 4) begin bad++; $display("FAIL two_latency got=%0d want=4", cyc); end
        total++; if (out_data !== exp) begin bad++; $display("FAIL two_data got=%0h want=%0h", out_data, exp); end
        consume();
    endtask

    task automatic test_backpressure();
        int cyc;
        send_beat(rep(16'h0001), ramp(), 1'b1);
        wait_valid(cyc);
        in_valid = 1'b1; a = rep(16'h0007); b = rep(16'h0007); in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid k=%0d got=%0b want=1", k, out_valid); end
            total++; if (out_data !== 48'd44) begin bad++; $display("FAIL bp_data k=%0d got=%0h want=2c", k, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready k=%0d got=%0b want=0", k, in_ready); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        consume();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_after_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_after_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_sign();
        int cyc;
        logic [47:0] exp;
`ifdef DOT_SIGNED_EN
        exp = 48'hFFFFFFFFFFFD;
`else
        exp = 48'h2FFFD;
`endif
        send_beat(128'h0000_FFFF, 128'h0000_0003, 1'b1);
        wait_valid(cyc);
        total++; if (out_data !== exp) begin bad++; $display("FAIL sign_data got=%0h want=%0h", out_data, exp); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL sign_ovf got=%0b want=0", out_ovf); end
        consume();
    endtask

    task automatic test_overflow();
        int cyc;
        logic exp_ovf;
        logic [47:0] exp48;
`ifdef DOT_SIGNED_EN
        exp_ovf = 1'b0;
        exp48   = 48'h8;
`else
        exp_ovf = 1'b1;
        exp48   = 48'h7_FFF0_0008;
`endif
        send_beat(rep(16'hFFFF), rep(16'hFFFF), 1'b1);
        wait_valid(cyc);
        total++; if (out_valid20 !== 1'b1) begin bad++; $display("FAIL ovf_valid20 got=%0b want=1", out_valid20); end
        total++; if (out_data20 !== 20'h00008) begin bad++; $display("FAIL ovf_data20 got=%0h want=8", out_data20); end
        total++; if (out_ovf20 !== exp_ovf) begin bad++; $display("FAIL ovf_flag20 got=%0b want=%0b", out_ovf20, exp_ovf); end
        total++; if (out_data !== exp48) begin bad++; $display("FAIL ovf_data48 got=%0h want=%0h", out_data, exp48); end
        consume();
        send_beat(rep(16'h0001), ramp(), 1'b1);
        wait_valid(cyc);
        total++; if (out_data20 !== 20'd44) begin bad++; $display("FAIL ovf_next_data20 got=%0h want=2c", out_data20); end
        total++; if (out_ovf20 !== 1'b0) begin bad++; $display("FAIL ovf_next_flag20 got=%0b want=0", out_ovf20); end
        consume();
    endtask

    task automatic test_abort(input bit use_clear);
        int cyc;
        bit seen;
        send_beat(rep(16'h0003), rep(16'h0005), 1'b1);
        tick(); tick();
        // A beat offered alongside the abort must not be taken.
        in_valid = 1'b1; a = rep(16'h0009); b = rep(16'h0009); in_last = 1'b1;
        if (use_clear) clear = 1'b1;
        else           rst   = 1'b1;
        tick();
        clear = 1'b0; rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort%0b_ready got=%0b want=1", use_clear, in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort%0b_valid got=%0b want=0", use_clear, out_valid); end
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort%0b_partial got=%0b want=0", use_clear, seen); end
        send_beat(rep(16'h0001), ramp(), 1'b1);
        wait_valid(cyc);
        total++; if (out_data !== 48'd44) begin bad++; $display("FAIL abort%0b_next got=%0h want=2c", use_clear, out_data); end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_beats();
        test_backpressure();
        test_sign();
        test_overflow();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dot_digit_accum.md
# dot_digit_accum

Parametrised digit-serial dot-product accumulator for the systolic datapath. It accepts beats of LANES element pairs and processes one DIGIT_W-bit digit of every A element per cycle against the full B element. Results accumulate across beats until a beat marked last, then drain through a valid/ready output. It generalises the fixed 8-element, 16-bit nibble-split calculation stage with configurable lanes, widths, multi-beat accumulation, backpressure and overflow reporting.

## Interface
- LANES, 8, element pairs per beat
- ELEM_W, 16, element width; must be a multiple of DIGIT_W
- DIGIT_W, 4, digit width processed per cycle
- ACC_W, 48, accumulator/result width; wraps modulo 2^ACC_W
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort: drop accumulation, return to IDLE
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready at a rising edge
- in_last  in  1  beat closes the accumulation
- a  in  LANES*ELEM_W  element i at [i*ELEM_W +: ELEM_W]
- b  in  LANES*ELEM_W  same packing
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACC_W  accumulated dot product
- out_ovf  out  1  sticky: some addition in this accumulation wrapped

## Operation
- Let D = ELEM_W/DIGIT_W (4 by default). States: IDLE, COMPUTE, HOLD.
- IDLE: in_ready=1. On accept, register a, b and in_last, set digit counter d=0, go to COMPUTE.
- COMPUTE: in_ready=0. Each cycle computes partial = sum over i of (digit d of a_i) * b_i, extends it to ACC_W, adds it shifted left by d*DIGIT_W to acc, then increments d.
- After digit D-1: if the registered last flag is 1, go to HOLD; otherwise go to IDLE and keep acc and ovf.
- HOLD: out_valid=1, out_data=acc, out_ovf=ovf. On out_ready, clear acc and ovf and go to IDLE. in_ready stays 0 while in HOLD.
- Unsigned arithmetic by default. ovf is set on carry out of ACC_W on any accumulator addition.
- clear in any state: next state IDLE, acc=0, ovf=0, out_valid=0. A beat offered in the same cycle is not accepted.
- rst has priority over clear and over every handshake.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_ovf=0, acc=0, d=0, state IDLE.
- Beat accepted at edge t: digit d is accumulated at edge t+1+d.
- For a last beat, out_valid is first high in the cycle after edge t+D, i.e. D cycles after acceptance.
- Throughput: one beat per D+1 cycles.
- out_data and out_ovf hold stable while out_valid && !out_ready.
- The next beat can be accepted at the first edge after the out_ready handshake.
- Reset or clear mid-COMPUTE discards the beat; there is no partial output.

## Configuration
- DOT_SIGNED_EN defined: a and b are two's complement.
  - The top digit of each a_i is signed; lower digits are unsigned.
  - b_i is sign-extended.
  - out_data is a signed ACC_W value.
  - ovf flags signed overflow on addition.
- Not defined: everything is unsigned, and ovf is the unsigned carry out.

## Structure
- Package dot_pkg holds:
  - the state enum (IDLE/COMPUTE/HOLD);
  - the localparam helpers: D, PART_W = DIGIT_W+ELEM_W+$clog2(LANES) (+1 when signed), and the minimum-ACC_W check.
- One sub-module, dot_digit_tree: a combinational block of LANES digit-by-element multipliers plus an adder tree, producing partial.
- The top level contains the FSM, digit counter, operand registers, accumulator and handshakes.

## Test plan
- Single last beat, defaults: a_i=1, b_i=i+2 (i=0..7) -> out_valid 4 cycles after accept, out_data=44, out_ovf=0.
- Two beats: beat 1 has a_i=0xFFFF, b_i=1, last=0; beat 2 has a_i=1, b_i=1, last=1 -> out_data=0x80000. in_ready is low during COMPUTE and HOLD, and there is no out_valid after beat 1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid and out_data stay 44, in_ready stays 0, and a beat offered meanwhile is not accepted.
- Sign handling: a_0=0xFFFF, b_0=3, all other elements 0:
  - with DOT_SIGNED_EN -> out_data=0xFFFFFFFFFFFD;
  - without -> out_data=0x2FFFD.
- Overflow with ACC_W=20 (unsigned): all a_i=b_i=0xFFFF, last=1 -> out_data=0x00008, out_ovf=1. The next single-beat result has out_ovf=0.
- rst pulsed at digit 2 of a beat -> next cycle in_ready=1, out_valid=0. A following beat with a_i=1, b_i=i+2 yields 44. Repeat using clear instead of rst -> same result.
